instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/multicore_pkg.sv | 20 ++
 rtl/fetch_hold_buf.sv | 31 +++
 rtl/instr_fetch.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared fetch-stage types and constants: instruction width, NOOP encoding, fetch FSM states.
package multicore_pkg;

  localparam int INST_SIZE = 32;

  // ADDI x0, x0, 0
  localparam logic [INST_SIZE-1:0] NOOP_CODE = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2,
    HALT  = 2'd3
  } t_fetch_state;

  function automatic logic [INST_SIZE-1:0] pc_inc(input logic [INST_SIZE-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer holding an instruction word and its pc while decode is stalled.
module fetch_hold_buf
  import multicore_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [INST_SIZE-1:0] word_in,
  input  logic [INST_SIZE-1:0] pc_in,
  output logic                 valid,
  output logic [INST_SIZE-1:0] word,
  output logic [INST_SIZE-1:0] pc
);

  // Clear wins over load so a redirect always invalidates the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      word  <= NOOP_CODE;
      pc    <= {INST_SIZE{1'b0}};
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= word_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage with stall buffering and decode/execute redirects.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of aligning them.
module instr_fetch
  import multicore_pkg::*;
#(
  parameter logic [INST_SIZE-1:0] RESET_PC = 32'h0000_0000
)
(
  input  logic                 i_aclk,
  input  logic                 i_areset,
  input  logic                 i_stall,
  input  logic                 i_branch_valid,
  input  logic [INST_SIZE-1:0] i_branch_addr,
  input  logic                 i_exe_redirect,
  input  logic [INST_SIZE-1:0] i_exe_addr,
  output logic                 o_imem_req,
  output logic [INST_SIZE-1:0] o_imem_addr,
  input  logic                 i_imem_ack,
  input  logic [INST_SIZE-1:0] i_imem_rdata,
  output logic [INST_SIZE-1:0] o_instruction,
  output logic [INST_SIZE-1:0] o_pc,
  output logic [INST_SIZE-1:0] o_pcplus4,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                 o_misaligned,
`endif
  output logic                 o_flush
);

  t_fetch_state         state;
  logic [INST_SIZE-1:0] pc_q;
  logic [INST_SIZE-1:0] req_addr_q;
  logic                 redirect;
  logic                 accept;
  logic [INST_SIZE-1:0] raw_target;
  logic [INST_SIZE-1:0] target;
  logic                 buf_load;
  logic                 buf_clear;
  logic                 buf_valid;
  logic [INST_SIZE-1:0] buf_word;
  logic [INST_SIZE-1:0] buf_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                 misalign_hit;
`endif

  // Redirect selection; execute-stage redirect outranks decode-stage JAL.
  always_comb begin
    redirect   = i_exe_redirect | i_branch_valid;
    raw_target = i_exe_redirect ? i_exe_addr : i_branch_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
    target = raw_target;
    if (state == HALT) begin
      accept = i_exe_redirect && (i_exe_addr[1:0] == 2'b00);
    end else begin
      accept = redirect;
    end
    misalign_hit = accept && (state != HALT) && (target[1:0] != 2'b00);
`else
    target = raw_target & {{(INST_SIZE-2){1'b1}}, 2'b00};
    accept = redirect;
`endif
    buf_load  = (state == FETCH) && i_imem_ack && i_stall && !redirect;
    buf_clear = (state == HOLD) && (accept || !i_stall);
  end

  assign o_flush     = accept;
  assign o_imem_req  = ((state == FETCH) || (state == DROP)) && !i_areset;
  assign o_imem_addr = req_addr_q;

  fetch_hold_buf u_hold_buf (
    .clk     (i_aclk),
    .rst     (i_areset),
    .load    (buf_load),
    .clear   (buf_clear),
    .word_in (i_imem_rdata),
    .pc_in   (pc_q),
    .valid   (buf_valid),
    .word    (buf_word),
    .pc      (buf_pc)
  );

  // Fetch FSM; req_addr_q tracks pc_q in FETCH but freezes in DROP until the stale ack.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state         <= FETCH;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      o_instruction <= NOOP_CODE;
      o_pc          <= RESET_PC;
      o_pcplus4     <= pc_inc(RESET_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
      o_misaligned  <= 1'b0;
`endif
    end else begin
      if (!i_stall) begin
        o_instruction <= NOOP_CODE;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misalign_hit) begin
        state        <= HALT;
        o_misaligned <= 1'b1;
      end else
`endif
      case (state)
        FETCH: begin
          if (accept) begin
            pc_q <= target;
            if (i_imem_ack) begin
              req_addr_q <= target;
            end else begin
              state <= DROP;
            end
          end else if (i_imem_ack) begin
            pc_q       <= pc_inc(pc_q);
            req_addr_q <= pc_inc(pc_q);
            if (i_stall) begin
              state <= HOLD;
            end else begin
              o_instruction <= i_imem_rdata;
              o_pc          <= pc_q;
              o_pcplus4     <= pc_inc(pc_q);
            end
          end
        end
        HOLD: begin
          if (accept) begin
            pc_q       <= target;
            req_addr_q <= target;
            state      <= FETCH;
          end else if (!i_stall) begin
            if (buf_valid) begin
              o_instruction <= buf_word;
              o_pc          <= buf_pc;
              o_pcplus4     <= pc_inc(buf_pc);
            end
            state <= FETCH;
          end
        end
        DROP: begin
          if (accept) begin
            pc_q <= target;
          end
          if (i_imem_ack) begin
            req_addr_q <= accept ? target : pc_q;
            state      <= FETCH;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        HALT: begin
          if (accept) begin
            o_misaligned <= 1'b0;
            pc_q         <= target;
            req_addr_q   <= target;
            state        <= FETCH;
          end
        end
`endif
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (RESET_PC = 0x100); covers FETCH_MISALIGN_TRAP_EN when defined.
module tb_instr_fetch;
  import multicore_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 stall;
  logic                 br_valid;
  logic [INST_SIZE-1:0] br_addr;
  logic                 exe_redir;
  logic [INST_SIZE-1:0] exe_addr;
  logic                 imem_req;
  logic [INST_SIZE-1:0] imem_addr;
  logic                 imem_ack;
  logic [INST_SIZE-1:0] imem_rdata;
  logic [INST_SIZE-1:0] instruction;
  logic [INST_SIZE-1:0] pc;
  logic [INST_SIZE-1:0] pcplus4;
  logic                 flush;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                 misaligned;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .i_aclk         (clk),
    .i_areset       (rst),
    .i_stall        (stall),
    .i_branch_valid (br_valid),
    .i_branch_addr  (br_addr),
    .i_exe_redirect (exe_redir),
    .i_exe_addr     (exe_addr),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_ack     (imem_ack),
    .i_imem_rdata   (imem_rdata),
    .o_instruction  (instruction),
    .o_pc           (pc),
    .o_pcplus4      (pcplus4),
`ifdef FETCH_MISALIGN_TRAP_EN
    .o_misaligned   (misaligned),
`endif
    .o_flush        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = word_of(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_addr = 32'h0;
    exe_redir = 1'b0; exe_addr = 32'h0; imem_ack = 1'b0;
    repeat (2) tick;
    check_eq("rst_req",   {31'd0, imem_req}, 32'd0);
    check_eq("rst_instr", instruction, NOOP_CODE);
    check_eq("rst_pc",    pc, 32'h100);
    check_eq("rst_pc4",   pcplus4, 32'h104);

    rst = 1'b0; imem_ack = 1'b1; #1;
    check_eq("first_req",  {31'd0, imem_req}, 32'd1);
    check_eq("first_addr", imem_addr, 32'h100);
    check_eq("first_noop", instruction, NOOP_CODE);

    tick;
    check_eq("d0_pc",    pc, 32'h100);
    check_eq("d0_instr", instruction, 32'hC0DE_0100);
    check_eq("d0_pc4",   pcplus4, 32'h104);
    check_eq("d0_addr",  imem_addr, 32'h104);
    tick;
    check_eq("d1_pc",    pc, 32'h104);
    check_eq("d1_instr", instruction, 32'hC0DE_0104);

    // Stall with an ack on 0x108: word buffered, request dropped.
    stall = 1'b1; tick;
    check_eq("hold_req",   {31'd0, imem_req}, 32'd0);
    check_eq("hold_pc",    pc, 32'h104);
    check_eq("hold_instr", instruction, 32'hC0DE_0104);
    stall = 1'b0; imem_ack = 1'b0; tick;
    check_eq("rel_pc",    pc, 32'h108);
    check_eq("rel_instr", instruction, 32'hC0DE_0108);
    check_eq("rel_pc4",   pcplus4, 32'h10C);
    check_eq("rel_req",   {31'd0, imem_req}, 32'd1);
    check_eq("rel_addr",  imem_addr, 32'h10C);

    tick;
    check_eq("bubble_instr", instruction, NOOP_CODE);
    check_eq("bubble_pc",    pc, 32'h108);

    // Both redirects together: execute wins.
    br_valid = 1'b1; br_addr = 32'h200; exe_redir = 1'b1; exe_addr = 32'h300; imem_ack = 1'b1; #1;
    check_eq("prio_flush", {31'd0, flush}, 32'd1);
    tick;
    br_valid = 1'b0; exe_redir = 1'b0; #1;
    check_eq("prio_noflush", {31'd0, flush}, 32'd0);
    check_eq("prio_addr",    imem_addr, 32'h300);
    check_eq("prio_instr",   instruction, NOOP_CODE);
    check_eq("prio_pc",      pc, 32'h108);
    tick;
    check_eq("t300_pc",    pc, 32'h300);
    check_eq("t300_instr", instruction, 32'hC0DE_0300);

    // Redirect to 0x400 while 0x304 is pending with a delayed ack.
    imem_ack = 1'b0; exe_redir = 1'b1; exe_addr = 32'h400; tick;
    exe_redir = 1'b0; #1;
    check_eq("drop_addr",  imem_addr, 32'h304);
    check_eq("drop_req",   {31'd0, imem_req}, 32'd1);
    check_eq("drop_instr", instruction, NOOP_CODE);
    tick; tick;
    check_eq("drop_addr2", imem_addr, 32'h304);
    imem_ack = 1'b1; tick;
    check_eq("drop_done_addr",  imem_addr, 32'h400);
    check_eq("drop_done_instr", instruction, NOOP_CODE);
    check_eq("drop_done_pc",    pc, 32'h300);
    tick;
    check_eq("t400_pc",    pc, 32'h400);
    check_eq("t400_instr", instruction, 32'hC0DE_0400);

    // Redirect while holding a buffered word and still stalled.
    stall = 1'b1; tick;
    check_eq("h2_req", {31'd0, imem_req}, 32'd0);
    exe_redir = 1'b1; exe_addr = 32'h500; imem_ack = 1'b0; #1;
    check_eq("h2_flush", {31'd0, flush}, 32'd1);
    tick;
    exe_redir = 1'b0; #1;
    check_eq("h2_req2",  {31'd0, imem_req}, 32'd1);
    check_eq("h2_addr",  imem_addr, 32'h500);
    check_eq("h2_pc",    pc, 32'h400);
    stall = 1'b0; imem_ack = 1'b1; tick;
    check_eq("t500_pc",    pc, 32'h500);
    check_eq("t500_instr", instruction, 32'hC0DE_0500);

    // PC wrap at the top of the address space.
    br_valid = 1'b1; br_addr = 32'hFFFF_FFFC; tick;
    br_valid = 1'b0; #1;
    check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick;
    check_eq("wrap_pc",    pc, 32'hFFFF_FFFC);
    check_eq("wrap_pc4",   pcplus4, 32'h0);
    check_eq("wrap_instr", instruction, 32'h3F21_FFFC);
    check_eq("wrap_next",  imem_addr, 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
    exe_redir = 1'b1; exe_addr = 32'h202; #1;
    check_eq("trap_flush", {31'd0, flush}, 32'd1);
    tick;
    exe_redir = 1'b0; imem_ack = 1'b0; #1;
    check_eq("trap_mis", {31'd0, misaligned}, 32'd1);
    check_eq("trap_req", {31'd0, imem_req}, 32'd0);
    tick;
    check_eq("trap_noop", instruction, NOOP_CODE);
    check_eq("trap_mis2", {31'd0, misaligned}, 32'd1);
    check_eq("trap_req2", {31'd0, imem_req}, 32'd0);
    exe_redir = 1'b1; exe_addr = 32'h204; tick;
    exe_redir = 1'b0; #1;
    check_eq("trap_clr",  {31'd0, misaligned}, 32'd0);
    check_eq("trap_req3", {31'd0, imem_req}, 32'd1);
    check_eq("trap_addr", imem_addr, 32'h204);
`else
    exe_redir = 1'b1; exe_addr = 32'h202; tick;
    exe_redir = 1'b0; #1;
    check_eq("align_addr", imem_addr, 32'h200);
`endif

    // Reset in the middle of an outstanding request.
    imem_ack = 1'b0; tick;
    #2 rst = 1'b1; #1;
    check_eq("arst_req", {31'd0, imem_req}, 32'd0);
    tick;
    rst = 1'b0; #1;
    check_eq("arst_req2", {31'd0, imem_req}, 32'd1);
    check_eq("arst_addr", imem_addr, 32'h100);
    check_eq("arst_pc",   pc, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
